// File: rtl/simon_round_ctrl_if.sv
// Handshake bundle between the SIMON input/output stages and the round controller.
// The master drives requests and output acceptance; the slave (controller) drives strobes and status.
interface simon_round_ctrl_if;
   logic       newDATA;
   logic       newKEY;
   logic [7:0] infoIN;
   logic       loadDATA;
   logic       loadKEY;
   logic       keyLOAD;
   logic       dataLOAD;
   logic       rndEN;
   logic [6:0] rndCNT;
   logic       dir;
   logic       outVALID;
   logic       outREADY;
   logic       busy;
   logic [7:0] infoOUT;

   modport master (
      output newDATA, newKEY, infoIN, outREADY,
      input  loadDATA, loadKEY, keyLOAD, dataLOAD, rndEN, rndCNT, dir, outVALID, busy, infoOUT
   );

   modport slave (
      input  newDATA, newKEY, infoIN, outREADY,
      output loadDATA, loadKEY, keyLOAD, dataLOAD, rndEN, rndCNT, dir, outVALID, busy, infoOUT
   );
endinterface

// File: rtl/simon_round_ctrl.sv
// Round sequencing FSM for an iterative SIMON core: accepts keys and blocks, runs T rounds, holds the result.
// Define SIMON_DECRYPT_EN to add decryption (one-off KEYEXP schedule walk, then down-counting rounds).
module simon_round_ctrl #(
   parameter int N = 32,
   parameter int M = 4,
   parameter int T = 44
) (
   input logic               clk,
   input logic               rst,
   simon_round_ctrl_if.slave bus
);

   if (N < 1 || M < 2 || M > 4 || T < 1 || T > 127) begin : gBadParams
      $error("simon_round_ctrl: unsupported N/M/T combination");
   end

   localparam logic [6:0] LAST = 7'(T - 1);

   typedef enum logic [1:0] {
      IDLE,
`ifdef SIMON_DECRYPT_EN
      KEYEXP,
`endif
      RUN,
      OUT
   } state_t;

   state_t     state_q;
   logic       keyValid_q;
   logic       keyAccLast_q;
   logic       rndEn_q;
   logic       outValid_q;
   logic [6:0] rndCnt_q;
   logic [6:0] rndCnt_d;
   logic [7:0] info_q;
   logic       runDone;
   logic       keyAccept;
   logic       dataAccept;
`ifdef SIMON_DECRYPT_EN
   logic       keyExp_q;
   logic       dir_q;
`endif

   // Acceptance is decided in the cycle the request is seen so the input stage gets its pulse
   // immediately; a key accepted last cycle cannot be re-accepted, which keeps every strobe single-cycle.
   always_comb begin
      keyAccept  = 1'b0;
      dataAccept = 1'b0;
      if (!rst && state_q == IDLE) begin
         keyAccept  = bus.newKEY && !keyAccLast_q;
         dataAccept = bus.newDATA && keyValid_q && !keyAccept;
      end
   end

   always_comb begin
      runDone  = (rndCnt_q == LAST);
      rndCnt_d = rndCnt_q + 7'd1;
`ifdef SIMON_DECRYPT_EN
      if (dir_q) begin
         runDone  = (rndCnt_q == 7'd0);
         rndCnt_d = rndCnt_q - 7'd1;
      end
`endif
   end

   // Main controller: the counter and status flags move together with the state so every status
   // output comes straight from a flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         keyValid_q   <= 1'b0;
         keyAccLast_q <= 1'b0;
         rndEn_q      <= 1'b0;
         outValid_q   <= 1'b0;
         rndCnt_q     <= 7'd0;
         info_q       <= 8'h00;
`ifdef SIMON_DECRYPT_EN
         keyExp_q     <= 1'b0;
         dir_q        <= 1'b0;
`endif
      end else begin
         keyAccLast_q <= keyAccept;
         case (state_q)
            IDLE: begin
               if (keyAccept) begin
                  keyValid_q <= 1'b1;
`ifdef SIMON_DECRYPT_EN
                  keyExp_q   <= 1'b0;
`endif
               end else if (dataAccept) begin
                  info_q   <= bus.infoIN;
                  rndCnt_q <= 7'd0;
`ifdef SIMON_DECRYPT_EN
                  dir_q    <= bus.infoIN[6];
                  if (bus.infoIN[6] && !keyExp_q) begin
                     state_q <= KEYEXP;
                  end else begin
                     state_q <= RUN;
                     rndEn_q <= 1'b1;
                     if (bus.infoIN[6]) begin
                        rndCnt_q <= LAST;
                     end
                  end
`else
                  state_q  <= RUN;
                  rndEn_q  <= 1'b1;
`endif
               end
            end
`ifdef SIMON_DECRYPT_EN
            // The schedule walk ends on the last round index, which is exactly where decryption starts.
            KEYEXP: begin
               if (rndCnt_q == LAST) begin
                  state_q  <= RUN;
                  rndEn_q  <= 1'b1;
                  keyExp_q <= 1'b1;
               end else begin
                  rndCnt_q <= rndCnt_q + 7'd1;
               end
            end
`endif
            RUN: begin
               if (runDone) begin
                  state_q    <= OUT;
                  rndEn_q    <= 1'b0;
                  outValid_q <= 1'b1;
               end else begin
                  rndCnt_q <= rndCnt_d;
               end
            end
            OUT: begin
               if (bus.outREADY) begin
                  state_q    <= IDLE;
                  outValid_q <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.loadKEY  = keyAccept;
   assign bus.keyLOAD  = keyAccept;
   assign bus.loadDATA = dataAccept;
   assign bus.dataLOAD = dataAccept;
   assign bus.rndEN    = rndEn_q;
   assign bus.rndCNT   = rndCnt_q;
   assign bus.outVALID = outValid_q;
   assign bus.busy     = (state_q != IDLE);
   assign bus.infoOUT  = info_q;
`ifdef SIMON_DECRYPT_EN
   assign bus.dir      = dir_q;
`else
   assign bus.dir      = 1'b0;
`endif

endmodule

// File: tb/tb_simon_round_ctrl.sv
// Self-checking bench for simon_round_ctrl: fixed vector table, hand-written latency/hold/reset
// sequences, and a randomized run, all compared against a cycle-offset reference model.
module tb_simon_round_ctrl;
   localparam int T = 44;

   typedef struct packed {
      logic       loadDATA;
      logic       loadKEY;
      logic       keyLOAD;
      logic       dataLOAD;
      logic       rndEN;
      logic [6:0] rndCNT;
      logic       dir;
      logic       outVALID;
      logic       busy;
      logic [7:0] infoOUT;
   } outs_t;

   typedef struct packed {
      logic       rst;
      logic       newKEY;
      logic       newDATA;
      logic [7:0] info;
      logic       ready;
   } stim_t;

   typedef struct {
      stim_t s;
      outs_t e;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   simon_round_ctrl_if bus ();

   simon_round_ctrl #(.N(32), .M(4), .T(T)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int obsCyc      = 0;

   // Reference model: a block is described by its age (cycles since acceptance) and total busy length.
   bit       mKeyValid, mKeyExp, mLastKey, mActive, mDec, mWithExp, mDir;
   int       mAge, mE;
   int       mLastCnt;
   bit [7:0] mInfo;

   function automatic void modelReset();
      mKeyValid = 0; mKeyExp = 0; mLastKey = 0; mActive = 0; mDec = 0; mWithExp = 0; mDir = 0;
      mAge = 0; mE = 0; mLastCnt = 0; mInfo = 8'h00;
   endfunction

   function automatic outs_t modelOut(input stim_t s);
      outs_t o;
      int    r;
      bit    ka, da;
      o = '0;
      if (s.rst) return o;
      o.dir     = mDir;
      o.infoOUT = mInfo;
      o.rndCNT  = 7'(mLastCnt);
      if (mActive) begin
         o.busy = 1'b1;
         if (mAge <= mE) begin
            if (mWithExp && mAge <= T) begin
               o.rndCNT = 7'(mAge - 1);
            end else begin
               r        = mAge - (mE - T) - 1;
               o.rndEN  = 1'b1;
               o.rndCNT = mDec ? 7'(T - 1 - r) : 7'(r);
            end
         end else begin
            o.outVALID = 1'b1;
            o.rndCNT   = mDec ? 7'd0 : 7'(T - 1);
         end
      end else begin
         ka = s.newKEY && !mLastKey;
         da = s.newDATA && mKeyValid && !ka;
         o.loadKEY  = ka;
         o.keyLOAD  = ka;
         o.loadDATA = da;
         o.dataLOAD = da;
      end
      return o;
   endfunction

   function automatic void modelEdge(input stim_t s);
      bit ka, da;
      if (s.rst) begin
         modelReset();
         return;
      end
      if (mActive) begin
         mLastKey = 0;
         if (mAge <= mE) begin
            mAge++;
         end else if (s.ready) begin
            mActive  = 0;
            mLastCnt = mDec ? 0 : T - 1;
         end
      end else begin
         ka = s.newKEY && !mLastKey;
         da = s.newDATA && mKeyValid && !ka;
         mLastKey = ka;
         if (ka) begin
            mKeyValid = 1;
            mKeyExp   = 0;
         end
         if (da) begin
            mActive = 1;
            mAge    = 1;
            mInfo   = s.info;
`ifdef SIMON_DECRYPT_EN
            mDec     = s.info[6];
            mWithExp = mDec && !mKeyExp;
            if (mDec) mKeyExp = 1;
`else
            mDec     = 0;
            mWithExp = 0;
`endif
            mDir = mDec;
            mE   = mWithExp ? 2 * T : T;
         end
      end
   endfunction

   function automatic stim_t mk(input logic r, input logic nk, input logic nd,
                                input logic [7:0] inf, input logic rdy);
      stim_t s;
      s.rst = r; s.newKEY = nk; s.newDATA = nd; s.info = inf; s.ready = rdy;
      return s;
   endfunction

   function automatic outs_t mkOut(input logic ld, input logic lk, input logic kl, input logic dl,
                                   input logic en, input logic [6:0] cnt, input logic d,
                                   input logic ov, input logic bsy, input logic [7:0] inf);
      outs_t o;
      o.loadDATA = ld; o.loadKEY = lk; o.keyLOAD = kl; o.dataLOAD = dl; o.rndEN = en;
      o.rndCNT = cnt; o.dir = d; o.outVALID = ov; o.busy = bsy; o.infoOUT = inf;
      return o;
   endfunction

   function automatic outs_t sampleOutputs();
      return mkOut(bus.loadDATA, bus.loadKEY, bus.keyLOAD, bus.dataLOAD, bus.rndEN, bus.rndCNT,
                   bus.dir, bus.outVALID, bus.busy, bus.infoOUT);
   endfunction

   task automatic checkOutput(input string name, input outs_t act, input outs_t exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s cycle %0d: got %h required %h (got ld/lk/kl/dl=%b%b%b%b en=%b cnt=%0d dir=%b ov=%b busy=%b info=%h)",
                  name, obsCyc, act, exp, act.loadDATA, act.loadKEY, act.keyLOAD, act.dataLOAD,
                  act.rndEN, act.rndCNT, act.dir, act.outVALID, act.busy, act.infoOUT);
      end
   endtask

   task automatic checkValue(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("[TB] FAIL %s at cycle %0d: got %0d required %0d", name, obsCyc, act, exp);
      end
   endtask

   task automatic applyStimulus(input stim_t s, output outs_t o);
      rst          = s.rst;
      bus.newKEY   = s.newKEY;
      bus.newDATA  = s.newDATA;
      bus.infoIN   = s.info;
      bus.outREADY = s.ready;
      @(negedge clk);
      obsCyc = cyc;
      o = sampleOutputs();
      checkOutput("model", o, modelOut(s));
      @(posedge clk);
      modelEdge(s);
      cyc++;
      #1;
   endtask

   task automatic resetAndKey();
      outs_t o;
      applyStimulus(mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0), o);
      applyStimulus(mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b0), o);
      checkValue("key_load_pulse", int'(o.loadKEY && o.keyLOAD && !o.busy), 1);
      applyStimulus(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0), o);
      checkValue("key_pulse_single", int'(o.loadKEY || o.keyLOAD || o.busy), 0);
   endtask

   task automatic runBlock(input logic [7:0] info, output int latency, output int enCount,
                           output int firstEn, output int firstCnt, output int lastCnt,
                           output int dirRun);
      outs_t o;
      int    acc;
      latency = -1; enCount = 0; firstEn = -1; firstCnt = -1; lastCnt = -1; dirRun = -1; acc = -1;
      for (int i = 0; i < 10 && acc < 0; i++) begin
         applyStimulus(mk(1'b0, 1'b0, 1'b1, info, 1'b0), o);
         if (o.loadDATA) acc = obsCyc;
      end
      if (acc < 0) return;
      for (int i = 0; i < 300 && latency < 0; i++) begin
         applyStimulus(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1), o);
         if (o.rndEN) begin
            if (firstEn < 0) begin
               firstEn  = obsCyc - acc;
               firstCnt = int'(o.rndCNT);
               dirRun   = int'(o.dir);
            end
            enCount++;
            lastCnt = int'(o.rndCNT);
         end
         if (o.outVALID) latency = obsCyc - acc;
      end
   endtask

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t  vecs[8];
      outs_t o;
      stim_t s;
      int    lat, enCnt, firstEn, firstCnt, lastCnt, dirRun, holdCnt, ldCnt, ovCnt;
      bit    seen;

      vecs[0] = '{mk(1, 1, 1, 8'h00, 0), mkOut(0, 0, 0, 0, 0, 7'd0, 0, 0, 0, 8'h00)};
      vecs[1] = '{mk(0, 0, 1, 8'h00, 0), mkOut(0, 0, 0, 0, 0, 7'd0, 0, 0, 0, 8'h00)};
      vecs[2] = '{mk(0, 1, 1, 8'h05, 0), mkOut(0, 1, 1, 0, 0, 7'd0, 0, 0, 0, 8'h00)};
      vecs[3] = '{mk(0, 1, 1, 8'h05, 0), mkOut(1, 0, 0, 1, 0, 7'd0, 0, 0, 0, 8'h00)};
      vecs[4] = '{mk(0, 0, 1, 8'h00, 0), mkOut(0, 0, 0, 0, 1, 7'd0, 0, 0, 1, 8'h05)};
      vecs[5] = '{mk(0, 1, 0, 8'h00, 0), mkOut(0, 0, 0, 0, 1, 7'd1, 0, 0, 1, 8'h05)};
      vecs[6] = '{mk(1, 0, 0, 8'h00, 0), mkOut(0, 0, 0, 0, 0, 7'd0, 0, 0, 0, 8'h00)};
      vecs[7] = '{mk(0, 0, 1, 8'h00, 0), mkOut(0, 0, 0, 0, 0, 7'd0, 0, 0, 0, 8'h00)};

      modelReset();
      bus.newKEY = 1'b0; bus.newDATA = 1'b0; bus.infoIN = 8'h00; bus.outREADY = 1'b0;

      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i].s, o);
         checkOutput($sformatf("table[%0d]", i), o, vecs[i].e);
      end

      // Encrypt latency: rounds 0..T-1 on the T cycles after acceptance, result one cycle later.
      resetAndKey();
      for (int i = 0; i < 5; i++) applyStimulus(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1), o);
      runBlock(8'h80, lat, enCnt, firstEn, firstCnt, lastCnt, dirRun);
      checkValue("enc_latency", lat, T + 1);
      checkValue("enc_rnden_count", enCnt, T);
      checkValue("enc_first_rnden", firstEn, 1);
      checkValue("enc_first_cnt", firstCnt, 0);
      checkValue("enc_last_cnt", lastCnt, T - 1);
      checkValue("enc_dir", dirRun, 0);
      applyStimulus(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1), o);
      checkValue("enc_outvalid_one_cycle", int'(o.outVALID), 0);
      checkValue("enc_cnt_held", int'(o.rndCNT), T - 1);

      // Stalled output stage: result held while data requests are ignored.
      resetAndKey();
      ldCnt = 0;
      applyStimulus(mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b0), o);
      checkValue("stall_accept", int'(o.loadDATA), 1);
      seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         applyStimulus(mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b0), o);
         ldCnt += int'(o.loadDATA);
         if (o.outVALID) seen = 1;
      end
      holdCnt = seen ? 1 : 0;
      for (int i = 0; i < 19; i++) begin
         applyStimulus(mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b0), o);
         holdCnt += int'(o.outVALID);
         ldCnt   += int'(o.loadDATA);
      end
      checkValue("stall_outvalid_held", holdCnt, 20);
      applyStimulus(mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b1), o);
      ldCnt += int'(o.loadDATA);
      checkValue("stall_ready_cycle_valid", int'(o.outVALID), 1);
      checkValue("stall_no_load", ldCnt, 0);
      applyStimulus(mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b1), o);
      checkValue("stall_load_after_idle", int'(o.loadDATA), 1);

      // Reset in the middle of a run abandons the block and the key.
      resetAndKey();
      applyStimulus(mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b1), o);
      checkValue("rst_accept", int'(o.loadDATA), 1);
      seen = 0;
      for (int i = 0; i < 60 && !seen; i++) begin
         applyStimulus(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1), o);
         if (o.rndEN && o.rndCNT == 7'd20) seen = 1;
      end
      checkValue("rst_reached_round20", int'(seen), 1);
      applyStimulus(mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b1), o);
      checkValue("rst_outputs_zero", int'(o), 0);
      ovCnt = 0; ldCnt = 0;
      for (int i = 0; i < 60; i++) begin
         applyStimulus(mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b1), o);
         ovCnt += int'(o.outVALID);
         ldCnt += int'(o.loadDATA);
      end
      checkValue("rst_no_outvalid", ovCnt, 0);
      checkValue("rst_data_refused", ldCnt, 0);

`ifdef SIMON_DECRYPT_EN
      // First decrypt after a key load walks the schedule before running rounds downward.
      resetAndKey();
      runBlock(8'h40, lat, enCnt, firstEn, firstCnt, lastCnt, dirRun);
      checkValue("dec1_latency", lat, 2 * T + 1);
      checkValue("dec1_rnden_count", enCnt, T);
      checkValue("dec1_first_rnden", firstEn, T + 1);
      checkValue("dec1_first_cnt", firstCnt, T - 1);
      checkValue("dec1_last_cnt", lastCnt, 0);
      checkValue("dec1_dir", dirRun, 1);
      runBlock(8'h40, lat, enCnt, firstEn, firstCnt, lastCnt, dirRun);
      checkValue("dec2_latency", lat, T + 1);
      checkValue("dec2_first_rnden", firstEn, 1);
      checkValue("dec2_first_cnt", firstCnt, T - 1);
`endif

      // Randomized traffic including occasional resets, all checked against the model.
      for (int i = 0; i < 3000; i++) begin
         s.rst     = ($urandom_range(0, 299) == 0);
         s.newKEY  = ($urandom_range(0, 24) == 0);
         s.newDATA = 1'($urandom_range(0, 1));
         s.info    = 8'($urandom);
         s.ready   = ($urandom_range(0, 2) != 0);
         applyStimulus(s, o);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
